// File: rtl/wb_buffer_pkg.sv
// -----------------------------------------------------------------------------
// wb_buffer_pkg
// Shared types for the data-cache writeback buffer.
//   wb_entry_t      : one buffered eviction (valid flag, block address, block data)
//   drain_state_e   : drain controller states (IDLE, DRAIN)
//   offset_bits()   : number of byte-offset bits inside one cache block
// The entry struct is sized by WB_BLOCK_DW / WB_ADDRESS_BITS, so the top-level
// width parameters must keep these values.
// -----------------------------------------------------------------------------
package wb_buffer_pkg;

   localparam int WB_BLOCK_DW     = 256;
   localparam int WB_ADDRESS_BITS = 32;

   typedef struct packed {
      logic                       valid;
      logic [WB_ADDRESS_BITS-1:0] address;
      logic [WB_BLOCK_DW-1:0]     data;
   } wb_entry_t;

   typedef enum logic {
      IDLE  = 1'b0,
      DRAIN = 1'b1
   } drain_state_e;

   // Byte-offset width of a block: addresses are compared above this bit.
   function automatic int offset_bits(input int block_dw);
      return $clog2(block_dw / 8);
   endfunction

endpackage

// File: rtl/wb_match_cam.sv
// -----------------------------------------------------------------------------
// wb_match_cam
// Block-address CAM over the writeback buffer entries plus the push port.
// Returns a one-hot vector of the youngest hit (bits [DEPTH-1:0] = entries by
// physical index, bit [DEPTH] = the incoming push) and the data of that hit.
// Ports:
//   lookup_address_i : address being searched
//   entries_i        : all buffer entries
//   head_ptr_i       : index of the oldest entry, used to order by age
//   push_valid_i     : incoming push takes part in the search
//   push_address_i   : incoming push address
//   push_data_i      : incoming push data
//   hit_onehot_o     : youngest matching source, one-hot
//   hit_o            : any match
//   hit_data_o       : data of the youngest match
// -----------------------------------------------------------------------------
module wb_match_cam
   import wb_buffer_pkg::*;
#(
   parameter int DEPTH           = 4,
   parameter int ADDRESS_BITS    = WB_ADDRESS_BITS,
   parameter int DCACHE_BLOCK_DW = WB_BLOCK_DW
) (
   input  logic [ADDRESS_BITS-1:0]    lookup_address_i,
   input  wb_entry_t                  entries_i [DEPTH],
   input  logic [$clog2(DEPTH)-1:0]   head_ptr_i,
   input  logic                       push_valid_i,
   input  logic [ADDRESS_BITS-1:0]    push_address_i,
   input  logic [DCACHE_BLOCK_DW-1:0] push_data_i,
   output logic [DEPTH:0]             hit_onehot_o,
   output logic                       hit_o,
   output logic [DCACHE_BLOCK_DW-1:0] hit_data_o
);

   localparam int PTR_W  = $clog2(DEPTH);
   localparam int OFFSET = offset_bits(DCACHE_BLOCK_DW);

   logic [PTR_W-1:0] idx;

   // Shifting the XOR drops the byte offset so only block bits are compared.
   function automatic logic same_block(input logic [ADDRESS_BITS-1:0] a,
                                       input logic [ADDRESS_BITS-1:0] b);
      return ((a ^ b) >> OFFSET) == '0;
   endfunction

   // Walk entries oldest to youngest so later matches override earlier ones,
   // then let the push port override everything since it is younger still.
   always_comb begin
      hit_onehot_o = '0;
      hit_o        = 1'b0;
      hit_data_o   = '0;
      idx          = '0;
      for (int age = 0; age < DEPTH; age++) begin
         idx = head_ptr_i + PTR_W'(age);
         if (entries_i[idx].valid && same_block(entries_i[idx].address, lookup_address_i)) begin
            hit_onehot_o      = '0;
            hit_onehot_o[idx] = 1'b1;
            hit_o             = 1'b1;
            hit_data_o        = entries_i[idx].data;
         end
      end
      if (push_valid_i && same_block(push_address_i, lookup_address_i)) begin
         hit_onehot_o        = '0;
         hit_onehot_o[DEPTH] = 1'b1;
         hit_o               = 1'b1;
         hit_data_o          = push_data_i;
      end
   end

endmodule

// File: rtl/dcache_writeback_buffer.sv
// -----------------------------------------------------------------------------
// dcache_writeback_buffer
// Queues dirty-block evictions from the data cache and drains them to the
// memory write port. Read misses that hit a queued block are served from the
// buffer so a read never overtakes a pending write to the same block.
// Optional feature macro: WB_COALESCE_EN (push to a queued block overwrites it
// in place instead of allocating a new entry).
// Ports:
//   clk, rst            : clock, asynchronous active-high reset
//   wb_valid_i/ready_o  : eviction push handshake, wb_address_i/wb_data_i payload
//   rd_valid_i          : read-miss request at rd_address_i
//   flush_i             : force the buffer to drain to empty
//   mem_rd_*            : read forwarded to memory (buffer miss)
//   mem_wr_*            : head entry written to memory, accepted by mem_wr_ready_i
//   fwd_*               : read served from the buffer, one cycle after the request
//   empty_o, count_o    : occupancy status
// -----------------------------------------------------------------------------
module dcache_writeback_buffer
   import wb_buffer_pkg::*;
#(
   parameter int DCACHE_BLOCK_DW = WB_BLOCK_DW,
   parameter int ADDRESS_BITS    = WB_ADDRESS_BITS,
   parameter int DEPTH           = 4,
   parameter int DRAIN_THRESHOLD = 2,
   parameter int IDLE_TIMEOUT    = 16
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       wb_valid_i,
   output logic                       wb_ready_o,
   input  logic [ADDRESS_BITS-1:0]    wb_address_i,
   input  logic [DCACHE_BLOCK_DW-1:0] wb_data_i,
   input  logic                       rd_valid_i,
   input  logic [ADDRESS_BITS-1:0]    rd_address_i,
   input  logic                       flush_i,
   output logic                       mem_rd_valid_o,
   output logic [ADDRESS_BITS-1:0]    mem_rd_address_o,
   output logic                       mem_wr_valid_o,
   output logic [ADDRESS_BITS-1:0]    mem_wr_address_o,
   output logic [DCACHE_BLOCK_DW-1:0] mem_wr_data_o,
   input  logic                       mem_wr_ready_i,
   output logic                       fwd_valid_o,
   output logic [ADDRESS_BITS-1:0]    fwd_address_o,
   output logic [DCACHE_BLOCK_DW-1:0] fwd_data_o,
   output logic                       empty_o,
   output logic [$clog2(DEPTH):0]     count_o
);

   localparam int PTR_W  = $clog2(DEPTH);
   localparam int CNT_W  = $clog2(DEPTH) + 1;
   localparam int IDLE_W = $clog2(IDLE_TIMEOUT + 1);

   // Entry storage: valid bits are reset, address/data are plain storage.
   logic                       valid_q [DEPTH];
   logic                       valid_d [DEPTH];
   logic [ADDRESS_BITS-1:0]    addr_q  [DEPTH];
   logic [ADDRESS_BITS-1:0]    addr_d  [DEPTH];
   logic [DCACHE_BLOCK_DW-1:0] data_q  [DEPTH];
   logic [DCACHE_BLOCK_DW-1:0] data_d  [DEPTH];
   wb_entry_t                  entries [DEPTH];

   logic [PTR_W-1:0]  head_q, head_d;
   logic [PTR_W-1:0]  tail_q, tail_d;
   logic [CNT_W-1:0]  count_q, count_d;
   drain_state_e      state_q, state_d;
   logic [IDLE_W-1:0] idle_cnt_q, idle_cnt_d;

   logic                       fwd_valid_q, fwd_valid_d;
   logic [ADDRESS_BITS-1:0]    fwd_address_q, fwd_address_d;
   logic [DCACHE_BLOCK_DW-1:0] fwd_data_q, fwd_data_d;

   logic full, empty;
   logic pop;
   logic push_alloc, push_coalesce, push_any;
   logic rd_push_valid;

   logic [DEPTH:0]             rd_onehot, coal_onehot;
   logic                       rd_hit, coal_hit;
   logic [DCACHE_BLOCK_DW-1:0] rd_hit_data, coal_hit_data;
   logic                       unused_cam_outputs;

   assign full  = (count_q == CNT_W'(DEPTH));
   assign empty = (count_q == '0);

   for (genvar i = 0; i < DEPTH; i++) begin : g_entry_view
      assign entries[i] = '{valid: valid_q[i], address: addr_q[i], data: data_q[i]};
   end

   wb_match_cam #(
      .DEPTH           (DEPTH),
      .ADDRESS_BITS    (ADDRESS_BITS),
      .DCACHE_BLOCK_DW (DCACHE_BLOCK_DW)
   ) u_rd_cam (
      .lookup_address_i (rd_address_i),
      .entries_i        (entries),
      .head_ptr_i       (head_q),
      .push_valid_i     (rd_push_valid),
      .push_address_i   (wb_address_i),
      .push_data_i      (wb_data_i),
      .hit_onehot_o     (rd_onehot),
      .hit_o            (rd_hit),
      .hit_data_o       (rd_hit_data)
   );

   // Coalescing only looks at stored entries; the push itself is the lookup.
   wb_match_cam #(
      .DEPTH           (DEPTH),
      .ADDRESS_BITS    (ADDRESS_BITS),
      .DCACHE_BLOCK_DW (DCACHE_BLOCK_DW)
   ) u_coal_cam (
      .lookup_address_i (wb_address_i),
      .entries_i        (entries),
      .head_ptr_i       (head_q),
      .push_valid_i     (1'b0),
      .push_address_i   ('0),
      .push_data_i      ('0),
      .hit_onehot_o     (coal_onehot),
      .hit_o            (coal_hit),
      .hit_data_o       (coal_hit_data)
   );

   // A buffer hit suppresses the memory read; a forwarded read also blocks
   // the drain write because memory takes one dcache request per cycle.
   assign mem_rd_valid_o   = rd_valid_i & ~rd_hit;
   assign mem_rd_address_o = rd_address_i;
   assign mem_wr_valid_o   = (state_q == DRAIN) & ~empty & ~mem_rd_valid_o;
   assign mem_wr_address_o = addr_q[head_q];
   assign mem_wr_data_o    = data_q[head_q];
   assign pop              = mem_wr_valid_o & mem_wr_ready_i;

`ifdef WB_COALESCE_EN
   logic coal_on_popped_head;

   // Overwriting the head while it leaves would lose the write, so that case
   // falls back to allocating a fresh tail entry. The read lookup uses the
   // pop-independent form of acceptance to keep the path free of loops.
   assign coal_on_popped_head = coal_onehot[head_q] & pop;
   assign wb_ready_o          = ~full | (coal_hit & ~coal_on_popped_head);
   assign push_coalesce       = wb_valid_i & wb_ready_o & coal_hit & ~coal_on_popped_head;
   assign push_alloc          = wb_valid_i & wb_ready_o & ~push_coalesce;
   assign rd_push_valid       = wb_valid_i & (~full | coal_hit);
   assign unused_cam_outputs  = ^{rd_onehot, coal_onehot[DEPTH], coal_hit_data};
`else
   // A pop in the same cycle never makes room for a push.
   assign wb_ready_o         = ~full;
   assign push_coalesce      = 1'b0;
   assign push_alloc         = wb_valid_i & ~full;
   assign rd_push_valid      = push_alloc;
   assign unused_cam_outputs = ^{rd_onehot, coal_onehot, coal_hit, coal_hit_data};
`endif

   assign push_any = push_alloc | push_coalesce;

   // Next entry contents: retire the head, coalesce in place, or append.
   always_comb begin
      valid_d = valid_q;
      addr_d  = addr_q;
      data_d  = data_q;
      if (pop) begin
         valid_d[head_q] = 1'b0;
      end
      if (push_coalesce) begin
         for (int i = 0; i < DEPTH; i++) begin
            if (coal_onehot[i]) begin
               data_d[i] = wb_data_i;
            end
         end
      end
      if (push_alloc) begin
         valid_d[tail_q] = 1'b1;
         addr_d[tail_q]  = wb_address_i;
         data_d[tail_q]  = wb_data_i;
      end
   end

   // Pointers wrap naturally because DEPTH is a power of two.
   always_comb begin
      head_d  = head_q + PTR_W'(pop);
      tail_d  = tail_q + PTR_W'(push_alloc);
      count_d = count_q + CNT_W'(push_alloc) - CNT_W'(pop);
   end

   // Drain decision and idle counter. The counter runs only while idle and
   // saturates so a long quiet period cannot wrap it back below the timeout.
   always_comb begin
      state_d    = state_q;
      idle_cnt_d = idle_cnt_q;
      case (state_q)
         IDLE: begin
            if ((count_q >= CNT_W'(DRAIN_THRESHOLD)) ||
                ((idle_cnt_q == IDLE_W'(IDLE_TIMEOUT)) && !empty) ||
                flush_i) begin
               state_d = DRAIN;
            end
         end
         DRAIN: begin
            if ((count_d == '0) && !flush_i) begin
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
      if (push_any || (state_q != IDLE) || (state_d != IDLE)) begin
         idle_cnt_d = '0;
      end else if (idle_cnt_q != IDLE_W'(IDLE_TIMEOUT)) begin
         idle_cnt_d = idle_cnt_q + IDLE_W'(1);
      end
   end

   // Forward path: capture the hit data now, present it for one cycle next.
   always_comb begin
      fwd_valid_d   = rd_valid_i & rd_hit;
      fwd_address_d = fwd_address_q;
      fwd_data_d    = fwd_data_q;
      if (rd_valid_i && rd_hit) begin
         fwd_address_d = rd_address_i;
         fwd_data_d    = rd_hit_data;
      end
   end

   // Queue control state: reset discards every buffered entry.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         head_q  <= '0;
         tail_q  <= '0;
         count_q <= '0;
         for (int i = 0; i < DEPTH; i++) begin
            valid_q[i] <= 1'b0;
         end
      end else begin
         head_q  <= head_d;
         tail_q  <= tail_d;
         count_q <= count_d;
         valid_q <= valid_d;
      end
   end

   // Drain FSM with its idle counter and the registered forward strobe.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= IDLE;
         idle_cnt_q  <= '0;
         fwd_valid_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         idle_cnt_q  <= idle_cnt_d;
         fwd_valid_q <= fwd_valid_d;
      end
   end

   // Payload storage carries no reset; it is only read behind a valid bit.
   always_ff @(posedge clk) begin
      addr_q        <= addr_d;
      data_q        <= data_d;
      fwd_address_q <= fwd_address_d;
      fwd_data_q    <= fwd_data_d;
   end

   assign fwd_valid_o   = fwd_valid_q;
   assign fwd_address_o = fwd_address_q;
   assign fwd_data_o    = fwd_data_q;
   assign empty_o       = empty;
   assign count_o       = count_q;

endmodule

// File: tb/tb_dcache_writeback_buffer.sv
// -----------------------------------------------------------------------------
// tb_dcache_writeback_buffer
// Drives dcache_writeback_buffer through directed scenarios and a randomized
// phase, predicting every output from a queue-based reference model of the
// buffer (oldest block at the front, youngest at the back).
// -----------------------------------------------------------------------------
module tb_dcache_writeback_buffer;

   localparam int DW    = 256;
   localparam int AW    = 32;
   localparam int DEPTH = 4;
   localparam int THR   = 2;
   localparam int TMO   = 16;
   localparam int OFS   = 5;

   logic          clk = 1'b0;
   logic          rst;
   logic          wb_valid_i;
   logic          wb_ready_o;
   logic [AW-1:0] wb_address_i;
   logic [DW-1:0] wb_data_i;
   logic          rd_valid_i;
   logic [AW-1:0] rd_address_i;
   logic          flush_i;
   logic          mem_rd_valid_o;
   logic [AW-1:0] mem_rd_address_o;
   logic          mem_wr_valid_o;
   logic [AW-1:0] mem_wr_address_o;
   logic [DW-1:0] mem_wr_data_o;
   logic          mem_wr_ready_i;
   logic          fwd_valid_o;
   logic [AW-1:0] fwd_address_o;
   logic [DW-1:0] fwd_data_o;
   logic          empty_o;
   logic [2:0]    count_o;

   always #5 clk = ~clk;

   dcache_writeback_buffer #(
      .DCACHE_BLOCK_DW (DW),
      .ADDRESS_BITS    (AW),
      .DEPTH           (DEPTH),
      .DRAIN_THRESHOLD (THR),
      .IDLE_TIMEOUT    (TMO)
   ) dut (
      .clk              (clk),
      .rst              (rst),
      .wb_valid_i       (wb_valid_i),
      .wb_ready_o       (wb_ready_o),
      .wb_address_i     (wb_address_i),
      .wb_data_i        (wb_data_i),
      .rd_valid_i       (rd_valid_i),
      .rd_address_i     (rd_address_i),
      .flush_i          (flush_i),
      .mem_rd_valid_o   (mem_rd_valid_o),
      .mem_rd_address_o (mem_rd_address_o),
      .mem_wr_valid_o   (mem_wr_valid_o),
      .mem_wr_address_o (mem_wr_address_o),
      .mem_wr_data_o    (mem_wr_data_o),
      .mem_wr_ready_i   (mem_wr_ready_i),
      .fwd_valid_o      (fwd_valid_o),
      .fwd_address_o    (fwd_address_o),
      .fwd_data_o       (fwd_data_o),
      .empty_o          (empty_o),
      .count_o          (count_o)
   );

   typedef struct {
      logic [AW-1:0] addr;
      logic [DW-1:0] data;
   } blk_t;

   // Reference model state.
   blk_t          mq[$];
   bit            m_drain;
   int            m_idle;
   bit            m_fwd_v;
   logic [AW-1:0] m_fwd_a;
   logic [DW-1:0] m_fwd_d;

   int test_count = 0;
   int fail_count = 0;

   function automatic bit same_block(input logic [AW-1:0] a, input logic [AW-1:0] b);
      return a[AW-1:OFS] == b[AW-1:OFS];
   endfunction

   function automatic logic [DW-1:0] rand_data();
      logic [DW-1:0] d;
      for (int i = 0; i < DW / 32; i++) d[i*32 +: 32] = $urandom;
      return d;
   endfunction

   function automatic logic [AW-1:0] rand_addr();
      return AW'(32'h1000 * $urandom_range(1, 6) + $urandom_range(0, 31));
   endfunction

   task automatic checkOutput(input string tag, input logic [DW-1:0] observed,
                              input logic [DW-1:0] expected);
      test_count++;
      assert (observed === expected)
      else begin
         fail_count++;
         $error("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
      end
   endtask

   task automatic doReset();
      rst            = 1'b1;
      wb_valid_i     = 1'b0;
      wb_address_i   = '0;
      wb_data_i      = '0;
      rd_valid_i     = 1'b0;
      rd_address_i   = '0;
      flush_i        = 1'b0;
      mem_wr_ready_i = 1'b0;
      #1;
      checkOutput("rst_count", count_o, 0);
      checkOutput("rst_empty", empty_o, 1);
      checkOutput("rst_wb_ready", wb_ready_o, 1);
      checkOutput("rst_mem_wr_valid", mem_wr_valid_o, 0);
      checkOutput("rst_fwd_valid", fwd_valid_o, 0);
      @(negedge clk);
      rst = 1'b0;
      mq.delete();
      m_drain = 0;
      m_idle  = 0;
      m_fwd_v = 0;
   endtask

   // One clock cycle: drive inputs at the falling edge, check all outputs
   // against the model, advance the model, and wait for the next falling edge.
   task automatic applyStimulus(input bit wv, input logic [AW-1:0] wa, input logic [DW-1:0] wd,
                                input bit rv, input logic [AW-1:0] ra,
                                input bit fl, input bit mr);
      bit            full, push, hit, mrv, mwv, old_drain;
      int            old_size;
      logic [DW-1:0] hd;
      wb_valid_i     = wv;
      wb_address_i   = wa;
      wb_data_i      = wd;
      rd_valid_i     = rv;
      rd_address_i   = ra;
      flush_i        = fl;
      mem_wr_ready_i = mr;
      #1;
      full = (mq.size() == DEPTH);
      push = wv && !full;
      hit  = 0;
      hd   = '0;
      if (rv) begin
         if (push && same_block(wa, ra)) begin
            hit = 1;
            hd  = wd;
         end else begin
            for (int i = mq.size() - 1; i >= 0; i--) begin
               if (same_block(mq[i].addr, ra)) begin
                  hit = 1;
                  hd  = mq[i].data;
                  break;
               end
            end
         end
      end
      mrv = rv && !hit;
      mwv = m_drain && (mq.size() > 0) && !mrv;

      checkOutput("wb_ready", wb_ready_o, !full);
      checkOutput("count", count_o, mq.size());
      checkOutput("empty", empty_o, mq.size() == 0);
      checkOutput("mem_rd_valid", mem_rd_valid_o, mrv);
      if (mrv) checkOutput("mem_rd_address", mem_rd_address_o, ra);
      checkOutput("mem_wr_valid", mem_wr_valid_o, mwv);
      if (mq.size() > 0) begin
         checkOutput("mem_wr_address", mem_wr_address_o, mq[0].addr);
         checkOutput("mem_wr_data", mem_wr_data_o, mq[0].data);
      end
      checkOutput("fwd_valid", fwd_valid_o, m_fwd_v);
      if (m_fwd_v) begin
         checkOutput("fwd_address", fwd_address_o, m_fwd_a);
         checkOutput("fwd_data", fwd_data_o, m_fwd_d);
      end

      old_size  = mq.size();
      old_drain = m_drain;
      if (mwv && mr) void'(mq.pop_front());
      if (push) mq.push_back('{addr: wa, data: wd});
      if (!m_drain) m_drain = (old_size >= THR) || (m_idle == TMO && old_size > 0) || fl;
      else if (mq.size() == 0 && !fl) m_drain = 0;
      if (push || old_drain || m_drain) m_idle = 0;
      else if (m_idle < TMO) m_idle++;
      m_fwd_v = rv && hit;
      if (m_fwd_v) begin
         m_fwd_a = ra;
         m_fwd_d = hd;
      end
      @(negedge clk);
   endtask

   task automatic idleCycle(input bit mr);
      applyStimulus(0, '0, '0, 0, '0, 0, mr);
   endtask

   initial begin
      logic [DW-1:0] d0, d1, d2, da, db;
      d0 = {8{32'hD0D0_0000}};
      d1 = {8{32'hD1D1_1111}};
      d2 = {8{32'hD2D2_2222}};
      da = {8{32'hAAAA_5555}};
      db = {8{32'hBBBB_6666}};
      rst = 1'b1;
      @(negedge clk);

      // Lone push drains only after the idle timeout.
      doReset();
      applyStimulus(1, 32'h1000, d0, 0, '0, 0, 1);
      for (int i = 0; i < 22; i++) idleCycle(1);

      // Fill to full, refused push while full, no space freed by a same-cycle pop.
      doReset();
      for (int i = 0; i < 4; i++) applyStimulus(1, AW'(32'h6000 + 32'h100 * i), rand_data(), 0, '0, 0, 0);
      applyStimulus(1, 32'h6800, d2, 0, '0, 0, 0);
      applyStimulus(1, 32'h6800, d2, 0, '0, 0, 1);
      applyStimulus(1, 32'h6800, d2, 0, '0, 0, 0);
      for (int i = 0; i < 6; i++) idleCycle(1);

      // Read hit inside a buffered block, then a miss.
      doReset();
      applyStimulus(1, 32'h2000, d1, 0, '0, 0, 0);
      applyStimulus(0, '0, '0, 1, 32'h2010, 0, 0);
      applyStimulus(0, '0, '0, 1, 32'h3000, 0, 0);
      idleCycle(0);

      // Push and read to the same block in one cycle.
      applyStimulus(1, 32'h4000, d2, 1, 32'h4000, 0, 0);
      idleCycle(0);

      // Read miss during drain takes the memory slot from the write.
      applyStimulus(0, '0, '0, 1, 32'h7000, 0, 1);
      idleCycle(1);
      idleCycle(1);
      idleCycle(1);

      // Reset in the middle of a drain discards the entries.
      applyStimulus(1, 32'h2000, d0, 0, '0, 0, 0);
      applyStimulus(1, 32'h2100, d1, 0, '0, 0, 0);
      applyStimulus(0, '0, '0, 0, '0, 0, 0);
      doReset();
      idleCycle(1);

      // Two pushes to one block: separate entries drained oldest first.
      applyStimulus(1, 32'h5000, da, 0, '0, 0, 0);
      applyStimulus(1, 32'h5000, db, 0, '0, 0, 0);
      applyStimulus(0, '0, '0, 1, 32'h5004, 0, 0);
      for (int i = 0; i < 4; i++) idleCycle(1);

      // Flush forces an immediate drain of a partial buffer.
      applyStimulus(1, 32'h3000, d0, 0, '0, 0, 1);
      applyStimulus(0, '0, '0, 0, '0, 1, 1);
      for (int i = 0; i < 3; i++) idleCycle(1);

      // Randomized traffic over a small set of blocks to provoke hits.
      doReset();
      for (int i = 0; i < 800; i++) begin
         applyStimulus($urandom_range(0, 99) < 50, rand_addr(), rand_data(),
                       $urandom_range(0, 99) < 30, rand_addr(),
                       $urandom_range(0, 99) < 5,
                       $urandom_range(0, 99) < 60);
      end

      $display("[TB] %0d tests run, %0d failed", test_count, fail_count);
      $finish;
   end

endmodule

// File: doc/dcache_writeback_buffer.md
Name: dcache_writeback_buffer

Overview:
Sits between the data cache and the main memory controller on the data-side write path. It queues dirty-block evictions and drains them to the memory write port, one block per accepted cycle. Data-cache read misses pass through to memory unless they hit a queued block; a hit is served from the buffer, so a read never overtakes a pending write to the same block.

Parameters:
DCACHE_BLOCK_DW, 256, bits per data-cache block
ADDRESS_BITS, 32, address width
DEPTH, 4, buffer entries (power of 2, >=2)
DRAIN_THRESHOLD, 2, occupancy that starts draining
IDLE_TIMEOUT, 16, cycles with no push before a partial buffer drains

Ports:
clk  in  1  clock
rst  in  1  asynchronous active-high reset
wb_valid_i  in  1  eviction push request
wb_ready_o  out  1  buffer can accept a push
wb_address_i  in  ADDRESS_BITS  eviction block address
wb_data_i  in  DCACHE_BLOCK_DW  eviction data
rd_valid_i  in  1  read-miss request
rd_address_i  in  ADDRESS_BITS  read-miss address
flush_i  in  1  force drain to empty
mem_rd_valid_o  out  1  read forwarded to memory
mem_rd_address_o  out  ADDRESS_BITS  forwarded read address
mem_wr_valid_o  out  1  write issued to memory
mem_wr_address_o  out  ADDRESS_BITS  head address
mem_wr_data_o  out  DCACHE_BLOCK_DW  head data
mem_wr_ready_i  in  1  memory accepts the write this cycle
fwd_valid_o  out  1  read served from buffer
fwd_address_o  out  ADDRESS_BITS  served address
fwd_data_o  out  DCACHE_BLOCK_DW  served data
empty_o  out  1  no entries held
count_o  out  $clog2(DEPTH)+1  occupancy

Behaviour:
- Clock and reset: one clock, clk. Reset rst is asynchronous and active-high.
- Reset values: all pointers, count and FSM state are cleared and the state is IDLE. fwd_valid_o=0, mem_wr_valid_o=0, empty_o=1, count_o=0, wb_ready_o=1. Per-entry valid bits are cleared. Entry data is not reset. Reset mid-drain discards all entries.
- Block match: compare addresses on bits [ADDRESS_BITS-1:OFFSET], where OFFSET=$clog2(DCACHE_BLOCK_DW/8).
- Push: a push is accepted when wb_valid_i & wb_ready_o, and wb_ready_o = ~full.
  - A pop in the same cycle does not free space for that push; there is no full-bypass.
  - The entry is written at the tail, and count increments on the next edge.
- Read lookup (combinational): the lookup checks the incoming push first, then the youngest valid entry.
  - Hit: mem_rd_valid_o=0. One cycle later, fwd_valid_o=1 for exactly one cycle with the matched data registered, taken from wb_data_i if the push matched.
  - Hit on the head being popped this cycle: still forwarded, using the captured data.
  - Miss: mem_rd_valid_o=rd_valid_i and mem_rd_address_o=rd_address_i in the same cycle.
- Drain FSM:
  - IDLE -> DRAIN when any of these holds: count>=DRAIN_THRESHOLD; the idle counter reaches IDLE_TIMEOUT with count>0; flush_i.
  - DRAIN: mem_wr_valid_o = ~empty & ~mem_rd_valid_o. A forwarded read has priority because memory takes one dcache request per cycle.
  - Pop when mem_wr_valid_o & mem_wr_ready_i.
  - DRAIN -> IDLE when the buffer becomes empty (after the last pop) and flush_i is low.
- Idle counter: resets on any push or on leaving IDLE, and saturates at IDLE_TIMEOUT.
- Pointers: wrap modulo DEPTH. count_o runs 0..DEPTH.
- Registered outputs: mem_wr_* outputs come straight from the head entry registers.

Optional Feature:
WB_COALESCE_EN
- Defined: a push whose block matches a valid entry overwrites that entry's data in place. Count is unchanged, and wb_ready_o is asserted for the push even when the buffer is full.
  - Exception: if the match is the head being popped that cycle, the push allocates a new tail entry instead.
- Undefined: every push allocates a new entry, duplicates are allowed, and lookup returns the youngest match.

Decomposition:
- Package wb_buffer_pkg holds:
  - the wb_entry_t struct: valid, address, data;
  - the drain state enum: IDLE, DRAIN;
  - the OFFSET localparam function.
- One sub-module, wb_match_cam. It compares a lookup address against all entries plus the push port and returns a one-hot youngest-hit vector and hit data. The top level instantiates it twice: once for read lookup and once for coalescing.

Test Plan:
- Push 0x1000/D0 with DRAIN_THRESHOLD=2 -> no mem_wr_valid_o for 16 idle cycles, then mem_wr_address_o=0x1000; with mem_wr_ready_i=1, count_o 1->0 and empty_o=1.
- Push 4 blocks, then a 5th with ready held off -> wb_ready_o=0 at count 4. One pop plus a simultaneous push -> push refused that cycle, accepted next.
- Buffer holds 0x2000/D1, then rd_valid_i with 0x2010 -> mem_rd_valid_o=0 and next cycle fwd_valid_o=1, fwd_data_o=D1. Read 0x3000 -> mem_rd_valid_o=1 in the same cycle.
- Push 0x4000/D2 while reading 0x4000 in the same cycle -> forwarded D2, no memory read.
- During DRAIN, a read miss coincides with mem_wr_ready_i=1 -> mem_wr_valid_o=0 that cycle and the write issues the next cycle.
- WB_COALESCE_EN: push 0x5000/A, then 0x5000/B -> count_o=1, and the drained data is B. Without the macro -> count_o=2, drained in order A then B.
